// File: rtl/median_adaptive_binarize_if.sv
// Pixel stream bundle between the median-filter stage and the adaptive binarizer.
// Valid semantics: median_valid/bin_valid qualify the pixel in the same cycle; there is no
// back-pressure (no ready), so a pixel is consumed on every rising edge where valid is high.
interface median_adaptive_binarize_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  median_valid;
   logic                  median_hsync;
   logic                  median_vsync;
   logic [DATA_WIDTH-1:0] median_in;
   logic                  bin_valid;
   logic                  bin_hsync;
   logic                  bin_vsync;
   logic [DATA_WIDTH-1:0] bin_out;
   logic [DATA_WIDTH-1:0] threshold;
   logic                  thresh_update;

   modport master (
      output median_valid, median_hsync, median_vsync, median_in,
      input  bin_valid, bin_hsync, bin_vsync, bin_out, threshold, thresh_update
   );

   modport slave (
      input  median_valid, median_hsync, median_vsync, median_in,
      output bin_valid, bin_hsync, bin_vsync, bin_out, threshold, thresh_update
   );
endinterface

// File: rtl/median_adaptive_binarize.sv
// Binarizes each frame against the floor mean of the previous frame; the mean is
// computed by a serial restoring divider that runs while the next frame accumulates.
module median_adaptive_binarize #(
   parameter int DATA_WIDTH  = 8,
   parameter int CNT_WIDTH   = 20,
   parameter int INIT_THRESH = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   median_adaptive_binarize_if.slave pix,
   output logic [1:0] fsm_state
);
   localparam int SUM_WIDTH = DATA_WIDTH + CNT_WIDTH;
   localparam int STEP_W    = $clog2(SUM_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, UPDATE = 2'd2} state_t;

   state_t                state, state_next;
   logic                  vsync_d;
   logic [SUM_WIDTH-1:0]  sum;
   logic [CNT_WIDTH-1:0]  count;
   logic [SUM_WIDTH-1:0]  quo;
   logic [CNT_WIDTH-1:0]  rem;
   logic [CNT_WIDTH-1:0]  divisor;
   logic [STEP_W-1:0]     step;
   logic                  vs_rise, vs_fall, start_div;
   logic [CNT_WIDTH:0]    shifted;
   logic                  fits;

   assign vs_rise   = pix.median_vsync & ~vsync_d;
   assign vs_fall   = ~pix.median_vsync & vsync_d;
   assign start_div = (state == IDLE) && vs_fall && (count != '0);
   assign fsm_state = state;

   // One restoring step: bring down the next dividend bit, subtract if it fits.
   assign shifted = {rem, quo[SUM_WIDTH-1]};
   assign fits    = shifted >= {1'b0, divisor};

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_div) state_next = DIVIDE;
         DIVIDE:  if (step == STEP_W'(SUM_WIDTH - 1)) state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d           <= 1'b0;
         pix.bin_valid     <= 1'b0;
         pix.bin_hsync     <= 1'b0;
         pix.bin_vsync     <= 1'b0;
         pix.bin_out       <= '0;
         pix.threshold     <= DATA_WIDTH'(INIT_THRESH);
         pix.thresh_update <= 1'b0;
         sum               <= '0;
         count             <= '0;
         quo               <= '0;
         rem               <= '0;
         divisor           <= '0;
         step              <= '0;
      end else begin
         vsync_d       <= pix.median_vsync;
         pix.bin_valid <= pix.median_valid;
         pix.bin_hsync <= pix.median_hsync;
         pix.bin_vsync <= pix.median_vsync;
         pix.bin_out   <= (pix.median_valid && (pix.median_in > pix.threshold)) ? '1 : '0;

         // Accumulation saturates: once count is full, sum and count both freeze.
         if (vs_rise) begin
            sum   <= pix.median_valid ? SUM_WIDTH'(pix.median_in) : '0;
            count <= pix.median_valid ? CNT_WIDTH'(1) : '0;
         end else if (pix.median_vsync && pix.median_valid && pix.median_hsync &&
                      (count != CNT_MAX)) begin
            sum   <= sum + SUM_WIDTH'(pix.median_in);
            count <= count + 1'b1;
         end

         pix.thresh_update <= (state == UPDATE);

         case (state)
            IDLE: begin
               if (start_div) begin
                  quo     <= sum;
                  divisor <= count;
                  rem     <= '0;
                  step    <= '0;
               end
            end
            DIVIDE: begin
               quo  <= {quo[SUM_WIDTH-2:0], fits};
               rem  <= CNT_WIDTH'(fits ? (shifted - {1'b0, divisor}) : shifted);
               step <= step + 1'b1;
            end
            UPDATE: pix.threshold <= quo[DATA_WIDTH-1:0];
            default: ;
         endcase
      end
   end
endmodule

// File: doc/median_adaptive_binarize.md
MEDIAN_ADAPTIVE_BINARIZE -- requirements
Module: median_adaptive_binarize

Interface
REQ-001 Parameter DATA_WIDTH, default 8: gray pixel width.
REQ-002 Parameter CNT_WIDTH, default 20: pixel-counter width (max 2^20-1 pixels/frame).
REQ-003 Parameter INIT_THRESH, default 128: threshold after reset.
REQ-004 Local SUM_WIDTH SHALL equal DATA_WIDTH+CNT_WIDTH (28 by default).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 median_valid  in  1  pixel-valid from median-filter stage.
REQ-008 median_hsync  in  1  line sync, active-high during line.
REQ-009 median_vsync  in  1  frame sync, active-high during frame.
REQ-010 median_in  in  DATA_WIDTH  filtered gray pixel.
REQ-011 bin_valid / bin_hsync / bin_vsync  out  1 each  control signals, delayed 1 cycle.
REQ-012 bin_out  out  DATA_WIDTH  binary pixel: all-ones or zero.
REQ-013 threshold  out  DATA_WIDTH  threshold currently applied.
REQ-014 thresh_update  out  1  one-cycle pulse when threshold is rewritten.

Function
REQ-015 Pixel path latency SHALL be exactly 1 cycle; bin_valid/hsync/vsync SHALL be the inputs registered once.
REQ-016 With median_valid=1, bin_out SHALL be all-ones if median_in > threshold (strict), else zero; with median_valid=0, bin_out SHALL be zero.
REQ-017 Frame N SHALL be binarized with the mean of frame N-1; threshold SHALL NOT change while pixels of a frame are being compared except via REQ-024.
REQ-018 vsync_d SHALL register median_vsync; rising edge = vsync & ~vsync_d, falling edge = ~vsync & vsync_d.
REQ-019 On rising edge, sum and count SHALL clear; if median_valid is also 1 that cycle, sum<=median_in, count<=1.
REQ-020 While median_vsync=1 and median_valid=1 (and median_hsync=1), sum+=median_in, count+=1; at count=2^CNT_WIDTH-1 both SHALL hold (saturate).
REQ-021 FSM states IDLE, DIVIDE, UPDATE; reset state IDLE.
REQ-022 IDLE: on falling edge with count!=0, latch dividend=sum, divisor=count, go DIVIDE; with count=0 stay IDLE, threshold unchanged, no pulse.
REQ-023 DIVIDE: restoring unsigned division, one quotient bit per cycle MSB-first, exactly SUM_WIDTH cycles, then UPDATE.
REQ-024 UPDATE (1 cycle): threshold <= quotient[DATA_WIDTH-1:0] (floor mean), thresh_update=1, return IDLE; threshold and pulse change at the (SUM_WIDTH+1)th clock edge after the edge detecting the falling vsync.
REQ-025 Divider operands SHALL be latched copies; accumulation of a new frame SHALL proceed concurrently with DIVIDE.
REQ-026 A falling edge arriving while in DIVIDE or UPDATE SHALL be ignored (that frame gives no update); current division completes unaffected.
REQ-027 thresh_update SHALL be 0 in all states except UPDATE.

Reset
REQ-028 rst_n=0 SHALL immediately force: bin_valid/hsync/vsync=0, bin_out=0, thresh_update=0, threshold=INIT_THRESH, sum=count=0, vsync_d=0, FSM=IDLE, divider registers 0.
REQ-029 Reset during DIVIDE SHALL abort the division; threshold stays INIT_THRESH until a later complete frame.

Verification
REQ-030 Reset release, frame of pixels 200 and 100 (1-cycle valid each) -> bin_out 255 then 0 one cycle later; threshold=128.
REQ-031 4x2 frame all 100, vsync falls -> after 29 cycles threshold=100, thresh_update single pulse; next frame pixel 101->255, 100->0.
REQ-032 Frame pixels 10,20,30,41 (sum 101, count 4) -> threshold=25 (floor).
REQ-033 vsync pulse with no valid pixels -> threshold unchanged, thresh_update never asserted.
REQ-034 Second vsync fall 10 cycles after first (during DIVIDE) -> exactly one update, value from first frame.
REQ-035 rst_n low at cycle 15 of DIVIDE -> threshold=128 immediately, no thresh_update; next full frame of 60s -> threshold=60.
